// File: rtl/video_mixer.sv
// Multi-layer video compositor: two-stage pipeline with colour-key overlay, background
// fill and frame-synchronous double-buffered configuration.
module video_mixer #(
  parameter int unsigned NUM_LAYERS = 2,
  parameter int unsigned COLOR_BITS = 4,
  parameter bit          HSYNC_POL  = 1'b0,
  parameter bit          VSYNC_POL  = 1'b0
) (
  input  logic                              clk,
  input  logic                              reset_i,
  input  logic                              hsync_i,
  input  logic                              vsync_i,
  input  logic                              de_i,
  input  logic [NUM_LAYERS*3*COLOR_BITS-1:0] layer_rgb_i,
  input  logic                              cfg_we_i,
  input  logic [3:0]                        cfg_addr_i,
  input  logic [23:0]                       cfg_data_i,
  output logic                              hsync_o,
  output logic                              vsync_o,
  output logic                              de_o,
  output logic [COLOR_BITS-1:0]             r_o,
  output logic [COLOR_BITS-1:0]             g_o,
  output logic [COLOR_BITS-1:0]             b_o,
  output logic                              cfg_pending_o,
  output logic [15:0]                       frame_count_o
);

  localparam int unsigned CW = 3 * COLOR_BITS;

  typedef struct packed {
    logic [NUM_LAYERS-1:0]         layer_en;
    logic [NUM_LAYERS-1:0]         key_en;
    logic [CW-1:0]                 bg;
    logic [NUM_LAYERS-1:0][CW-1:0] key;
  } bank_t;

  localparam bank_t BANK_RST = '{layer_en: NUM_LAYERS'(1), key_en: '0, bg: '0, key: '0};

  // Stage 1: registered inputs
  logic                       hs1_q, vs1_q, de1_q;
  logic [NUM_LAYERS*CW-1:0]   rgb1_q;
  logic                       vs_prev_q;
  // Stage 2: registered outputs
  logic                       hs2_q, vs2_q, de2_q;
  logic [CW-1:0]              rgb2_q, rgb2_d;

  bank_t                      shadow_q, shadow_d, active_q, active_d;
  logic                       pending_q, pending_d;
  logic [15:0]                frame_q, frame_d;
  logic                       cfg_valid, boundary;
  logic [CW-1:0]              mix, pix;

  logic unused_cfg;
  assign unused_cfg = ^cfg_data_i;

  always_comb begin
    shadow_d  = shadow_q;
    cfg_valid = 1'b0;
    if (cfg_we_i) begin
      if (cfg_addr_i == 4'd0) begin
        shadow_d.layer_en = cfg_data_i[NUM_LAYERS-1:0];
        shadow_d.key_en   = cfg_data_i[8 +: NUM_LAYERS];
        cfg_valid         = 1'b1;
      end else if (cfg_addr_i == 4'd1) begin
        shadow_d.bg = cfg_data_i[CW-1:0];
        cfg_valid   = 1'b1;
      end else begin
        for (int unsigned n = 0; n < NUM_LAYERS; n++) begin
          if (cfg_addr_i == 4'(n + 2)) begin
            shadow_d.key[n] = cfg_data_i[CW-1:0];
            cfg_valid       = 1'b1;
          end
        end
      end
    end

    // Active bank takes the pre-write shadow; a same-cycle write stays pending.
    boundary  = (vs1_q == VSYNC_POL) && (vs_prev_q != VSYNC_POL);
    active_d  = boundary ? shadow_q : active_q;
    pending_d = cfg_valid ? 1'b1 : (boundary ? 1'b0 : pending_q);
    frame_d   = boundary ? frame_q + 16'd1 : frame_q;
  end

  always_comb begin
    mix = active_q.bg;
    pix = '0;
    for (int unsigned n = 0; n < NUM_LAYERS; n++) begin
      pix = rgb1_q[n*CW +: CW];
      if (active_q.layer_en[n] && !(active_q.key_en[n] && (pix == active_q.key[n]))) begin
        mix = pix;
      end
    end
    rgb2_d = de1_q ? mix : '0;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      hs1_q     <= ~HSYNC_POL;
      vs1_q     <= ~VSYNC_POL;
      de1_q     <= 1'b0;
      rgb1_q    <= '0;
      vs_prev_q <= ~VSYNC_POL;
      hs2_q     <= ~HSYNC_POL;
      vs2_q     <= ~VSYNC_POL;
      de2_q     <= 1'b0;
      rgb2_q    <= '0;
      shadow_q  <= BANK_RST;
      active_q  <= BANK_RST;
      pending_q <= 1'b0;
      frame_q   <= '0;
    end else begin
      hs1_q     <= hsync_i;
      vs1_q     <= vsync_i;
      de1_q     <= de_i;
      rgb1_q    <= layer_rgb_i;
      vs_prev_q <= vs1_q;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
      de2_q     <= de1_q;
      rgb2_q    <= rgb2_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      frame_q   <= frame_d;
    end
  end

  assign hsync_o       = hs2_q;
  assign vsync_o       = vs2_q;
  assign de_o          = de2_q;
  assign r_o           = rgb2_q[3*COLOR_BITS-1 -: COLOR_BITS];
  assign g_o           = rgb2_q[2*COLOR_BITS-1 -: COLOR_BITS];
  assign b_o           = rgb2_q[COLOR_BITS-1:0];
  assign cfg_pending_o = pending_q;
  assign frame_count_o = frame_q;

endmodule

// File: tb/tb_video_mixer.sv
// Self-checking bench for video_mixer: vector table plus scoreboarded config/frame sequences.
module tb_video_mixer;

  localparam int unsigned NL = 2;
  localparam int unsigned CB = 4;

  logic              clk = 1'b0;
  logic              reset_i;
  logic              hsync_i, vsync_i, de_i;
  logic [NL*3*CB-1:0] layer_rgb_i;
  logic              cfg_we_i;
  logic [3:0]        cfg_addr_i;
  logic [23:0]       cfg_data_i;
  logic              hsync_o, vsync_o, de_o;
  logic [CB-1:0]     r_o, g_o, b_o;
  logic              cfg_pending_o;
  logic [15:0]       frame_count_o;

  always #5 clk = ~clk;

  video_mixer #(.NUM_LAYERS(NL), .COLOR_BITS(CB), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) dut (
    .clk(clk), .reset_i(reset_i),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i), .layer_rgb_i(layer_rgb_i),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
    .r_o(r_o), .g_o(g_o), .b_o(b_o),
    .cfg_pending_o(cfg_pending_o), .frame_count_o(frame_count_o)
  );

  typedef struct {
    logic [14:0] exp;
    string       name;
  } sb_t;

  typedef struct {
    logic        hs, vs, de;
    logic [11:0] l0, l1;
    logic [14:0] exp;
  } vec_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic logic [14:0] e(input logic hs, input logic vs, input logic de,
                                    input logic [11:0] rgb);
    return {hs, vs, de, rgb};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic hs, input logic vs, input logic de,
                      input logic [11:0] l0, input logic [11:0] l1,
                      input logic [14:0] exp, input string name);
    sb_t ent;
    hsync_i     = hs;
    vsync_i     = vs;
    de_i        = de;
    layer_rgb_i = {l1, l0};
    ent.exp  = exp;
    ent.name = name;
    sb_q.push_back(ent);
    @(posedge clk);
    #1;
    if (sb_q.size() >= 2) begin
      ent = sb_q.pop_front();
      check(ent.name, {17'd0, hsync_o, vsync_o, de_o, r_o, g_o, b_o}, {17'd0, ent.exp});
    end
  endtask

  task automatic blank(input logic vs);
    step(1'b1, vs, 1'b0, 12'hFFF, 12'hFFF, e(1'b1, vs, 1'b0, 12'h000), "blank");
  endtask

  task automatic pix(input logic [11:0] l0, input logic [11:0] l1, input logic [11:0] rgb,
                     input string name);
    step(1'b1, 1'b1, 1'b1, l0, l1, e(1'b1, 1'b1, 1'b1, rgb), name);
  endtask

  task automatic vpulse();
    blank(1'b0);
    blank(1'b0);
    blank(1'b1);
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [23:0] data, input logic vs);
    cfg_we_i   = 1'b1;
    cfg_addr_i = addr;
    cfg_data_i = data;
    blank(vs);
    cfg_we_i   = 1'b0;
  endtask

  task automatic do_reset();
    sb_t ent;
    reset_i     = 1'b1;
    cfg_we_i    = 1'b0;
    hsync_i     = 1'b0;
    vsync_i     = 1'b1;
    de_i        = 1'b1;
    layer_rgb_i = '1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset_out", {17'd0, hsync_o, vsync_o, de_o, r_o, g_o, b_o},
            {17'd0, e(1'b1, 1'b1, 1'b0, 12'h000)});
    end
    check("reset_frame", {16'd0, frame_count_o}, 32'd0);
    check("reset_pending", {31'd0, cfg_pending_o}, 32'd0);
    sb_q.delete();
    reset_i  = 1'b0;
    ent.exp  = e(1'b1, 1'b1, 1'b0, 12'h000);
    ent.name = "post_reset_black";
    sb_q.push_back(ent);
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{hs: 1'b1, vs: 1'b1, de: 1'b1, l0: 12'hABC, l1: 12'hFFF, exp: e(1'b1, 1'b1, 1'b1, 12'hABC)};
    vecs[1] = '{hs: 1'b0, vs: 1'b1, de: 1'b1, l0: 12'h123, l1: 12'h456, exp: e(1'b0, 1'b1, 1'b1, 12'h123)};
    vecs[2] = '{hs: 1'b1, vs: 1'b1, de: 1'b0, l0: 12'hFFF, l1: 12'hFFF, exp: e(1'b1, 1'b1, 1'b0, 12'h000)};
    vecs[3] = '{hs: 1'b0, vs: 1'b1, de: 1'b0, l0: 12'hFFF, l1: 12'h000, exp: e(1'b0, 1'b1, 1'b0, 12'h000)};
    vecs[4] = '{hs: 1'b1, vs: 1'b1, de: 1'b1, l0: 12'h000, l1: 12'hFFF, exp: e(1'b1, 1'b1, 1'b1, 12'h000)};
    vecs[5] = '{hs: 1'b1, vs: 1'b1, de: 1'b1, l0: 12'hFFF, l1: 12'h000, exp: e(1'b1, 1'b1, 1'b1, 12'hFFF)};

    cfg_addr_i = '0;
    cfg_data_i = '0;
    do_reset();

    // Default config: layer 0 passthrough with 2-cycle latency
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].hs, vecs[i].vs, vecs[i].de, vecs[i].l0, vecs[i].l1, vecs[i].exp, "table");
    end
    check("no_frame_yet", {16'd0, frame_count_o}, 32'd0);

    // Key overlay
    cfg_write(4'd0, 24'h000203, 1'b1);
    cfg_write(4'd3, 24'h000000, 1'b1);
    check("pending_after_write", {31'd0, cfg_pending_o}, 32'd1);
    pix(12'h123, 12'hF00, 12'h123, "shadow_not_active");
    vpulse();
    check("frame1", {16'd0, frame_count_o}, 32'd1);
    check("pending_clear1", {31'd0, cfg_pending_o}, 32'd0);
    pix(12'h123, 12'h000, 12'h123, "key_transparent");
    pix(12'h123, 12'hF00, 12'hF00, "overlay_opaque");
    pix(12'h0AB, 12'h0F0, 12'h0F0, "overlay_opaque2");

    // Mid-frame write held until vsync
    cfg_write(4'd0, 24'h000001, 1'b1);
    check("pending_mid", {31'd0, cfg_pending_o}, 32'd1);
    pix(12'h123, 12'hF00, 12'hF00, "mid_frame_unchanged");
    vpulse();
    check("frame2", {16'd0, frame_count_o}, 32'd2);
    check("pending_clear2", {31'd0, cfg_pending_o}, 32'd0);
    pix(12'h123, 12'hF00, 12'h123, "new_cfg_applied");

    // Background only
    cfg_write(4'd0, 24'h000000, 1'b1);
    cfg_write(4'd1, 24'h0000F0, 1'b1);
    vpulse();
    pix(12'hABC, 12'hF00, 12'h0F0, "background");
    step(1'b1, 1'b1, 1'b0, 12'hABC, 12'hF00, e(1'b1, 1'b1, 1'b0, 12'h000), "bg_blanked");
    check("frame3", {16'd0, frame_count_o}, 32'd3);

    // Write on the boundary cycle itself
    cfg_write(4'd1, 24'h00000F, 1'b1);
    blank(1'b0);
    cfg_write(4'd0, 24'h000003, 1'b0);
    blank(1'b1);
    check("frame4", {16'd0, frame_count_o}, 32'd4);
    check("pending_boundary_write", {31'd0, cfg_pending_o}, 32'd1);
    pix(12'hABC, 12'hF00, 12'h00F, "old_shadow_applied");
    vpulse();
    check("frame5", {16'd0, frame_count_o}, 32'd5);
    check("pending_clear5", {31'd0, cfg_pending_o}, 32'd0);
    pix(12'hABC, 12'hF00, 12'hF00, "boundary_write_later");

    // Out-of-range address is ignored
    cfg_write(4'd4, 24'h000001, 1'b1);
    check("invalid_addr_no_pending", {31'd0, cfg_pending_o}, 32'd0);
    vpulse();
    pix(12'hABC, 12'hF00, 12'hF00, "invalid_addr_no_effect");
    check("frame6", {16'd0, frame_count_o}, 32'd6);

    // Counter wrap via fast vsync toggling
    sb_q.delete();
    de_i = 1'b0;
    for (int i = 0; i < 65529; i++) begin
      vsync_i = 1'b0;
      @(posedge clk);
      #1;
      vsync_i = 1'b1;
      @(posedge clk);
      #1;
    end
    check("frame_ffff", {16'd0, frame_count_o}, 32'h0000FFFF);
    vsync_i = 1'b0;
    @(posedge clk);
    #1;
    vsync_i = 1'b1;
    @(posedge clk);
    #1;
    check("frame_wrap", {16'd0, frame_count_o}, 32'd0);

    // Mid-frame reset
    pix(12'hABC, 12'hF00, 12'hF00, "pre_reset");
    pix(12'hABC, 12'hF00, 12'hF00, "pre_reset2");
    do_reset();
    pix(12'h123, 12'hF00, 12'h123, "reset_active_bank");
    pix(12'h456, 12'hF00, 12'h456, "reset_active_bank2");
    vpulse();
    pix(12'h789, 12'hF00, 12'h789, "reset_shadow_bank");
    check("frame_after_reset", {16'd0, frame_count_o}, 32'd1);
    blank(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
